hram_arbiter: RTL and testbench



---
 rtl/hram_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_hram_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hram_arbiter.sv
// hram_arbiter: two-port front end for the shared HyperRAM transaction engine.
// One request at a time is latched, its length validated, issued to the engine
// as a single burst and owned until eng_done. Write/read data is routed to the
// granted port, and a CS# high gap is enforced before the next burst.
//
// state  | meaning
// IDLE   | no burst owned; pick a winner among pending requests
// CHECK  | command latched in eng_* regs; validate burst length
// ISSUE  | one-cycle eng_start to the engine
// ACTIVE | burst in flight; data routed by gnt until eng_done
// GAP    | CS# high gap countdown; gnt still held, no new issue

module hram_arbiter #(
    parameter int MAX_LEN     = 64,
    parameter int CSHI_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [31:0] addr_a,
    input  logic [31:0] addr_b,
    input  logic [7:0]  len_a,
    input  logic [7:0]  len_b,
    input  logic [15:0] wdata_a,
    input  logic [15:0] wdata_b,
    output logic        wreq_a,
    output logic        wreq_b,
    output logic [15:0] rdata,
    output logic        rvalid_a,
    output logic        rvalid_b,
    output logic        done_a,
    output logic        done_b,
    output logic        err_a,
    output logic        err_b,
    output logic        eng_start,
    output logic        eng_we,
    output logic [31:0] eng_addr,
    output logic [7:0]  eng_len,
    output logic [15:0] eng_wdata,
    input  logic        eng_wreq,
    input  logic [15:0] eng_rdata,
    input  logic        eng_rvalid,
    input  logic        eng_done
);

    localparam int GAP_W = (CSHI_CYCLES > 1) ? $clog2(CSHI_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(CSHI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       gnt;        // bit 0 = port A, bit 1 = port B
    logic             rr_ptr;     // 0 = A wins a tie, 1 = B wins a tie
    logic [GAP_W-1:0] gap_cnt;

    logic             pick_b;
    logic             grant_now;
    logic             len_bad;
    logic             burst_end;
    logic             gap_end;

    // Arbitration and phase-end decode. A grant is held off while a done pulse
    // is out so the finishing requester gets that cycle to drop its request.
    always_comb begin
        pick_b    = req_b & (~req_a | rr_ptr);
        grant_now = (state == S_IDLE) & (req_a | req_b) & ~done_a & ~done_b;
        len_bad   = (eng_len == 8'd0) || (int'({24'd0, eng_len}) > MAX_LEN);
        burst_end = (state == S_ACTIVE) & eng_done;
        gap_end   = (state == S_GAP) && (gap_cnt == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_now) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                state_nxt = len_bad ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (eng_done) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode: issue strobe plus zero-latency data routing on gnt.
    always_comb begin
        eng_start = (state == S_ISSUE);
        wreq_a    = 1'b0;
        wreq_b    = 1'b0;
        rvalid_a  = 1'b0;
        rvalid_b  = 1'b0;
        rdata     = '0;
        eng_wdata = '0;
        if (gnt[0]) begin
            eng_wdata = wdata_a;
        end else if (gnt[1]) begin
            eng_wdata = wdata_b;
        end
        if (state == S_ACTIVE) begin
            wreq_a   = eng_wreq & gnt[0];
            wreq_b   = eng_wreq & gnt[1];
            rvalid_a = eng_rvalid & gnt[0];
            rvalid_b = eng_rvalid & gnt[1];
            rdata    = eng_rdata;
        end
    end

    // Grant ownership and round-robin pointer; the pointer moves to the other
    // port whenever the owner completes, with or without error.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt    <= 2'b00;
            rr_ptr <= 1'b0;
        end else begin
            if (grant_now) begin
                gnt <= pick_b ? 2'b10 : 2'b01;
            end else if ((state == S_CHECK) && len_bad) begin
                gnt    <= 2'b00;
                rr_ptr <= gnt[0];
            end else if (burst_end) begin
                rr_ptr <= gnt[0];
            end else if (gap_end) begin
                gnt <= 2'b00;
            end
        end
    end

    // Command latch for the winner; held stable through the whole burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_we   <= 1'b0;
            eng_addr <= '0;
            eng_len  <= '0;
        end else if (grant_now) begin
            eng_we   <= pick_b ? we_b   : we_a;
            eng_addr <= pick_b ? addr_b : addr_a;
            eng_len  <= pick_b ? len_b  : len_a;
        end
    end

    // CS# high gap down-counter, loaded on eng_done, terminal count at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (burst_end) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == S_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Completion pulses: rejected length from CHECK, or burst finished.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_a  <= 1'b0;
            err_b  <= 1'b0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            err_a  <= 1'b0;
            err_b  <= 1'b0;
            if ((state == S_CHECK) && len_bad) begin
                done_a <= gnt[0];
                done_b <= gnt[1];
                err_a  <= gnt[0];
                err_b  <= gnt[1];
            end else if (burst_end) begin
                done_a <= gnt[0];
                done_b <= gnt[1];
            end
        end
    end

endmodule

// File: tb/tb_hram_arbiter.sv
// Self-checking bench for hram_arbiter. The bench plays both requesters and
// the HyperRAM engine; a negedge monitor logs DUT events and captured data.
module tb_hram_arbiter;

    localparam int MAX_LEN     = 64;
    localparam int CSHI_CYCLES = 4;

    logic        clk;
    logic        rst;
    logic        req_a, req_b, we_a, we_b;
    logic [31:0] addr_a, addr_b;
    logic [7:0]  len_a, len_b;
    logic [15:0] wdata_a, wdata_b;
    logic        wreq_a, wreq_b;
    logic [15:0] rdata;
    logic        rvalid_a, rvalid_b;
    logic        done_a, done_b, err_a, err_b;
    logic        eng_start, eng_we;
    logic [31:0] eng_addr;
    logic [7:0]  eng_len;
    logic [15:0] eng_wdata;
    logic        eng_wreq;
    logic [15:0] eng_rdata;
    logic        eng_rvalid;
    logic        eng_done;

    hram_arbiter #(
        .MAX_LEN    (MAX_LEN),
        .CSHI_CYCLES(CSHI_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .len_a     (len_a),
        .len_b     (len_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .wreq_a    (wreq_a),
        .wreq_b    (wreq_b),
        .rdata     (rdata),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .done_a    (done_a),
        .done_b    (done_b),
        .err_a     (err_a),
        .err_b     (err_b),
        .eng_start (eng_start),
        .eng_we    (eng_we),
        .eng_addr  (eng_addr),
        .eng_len   (eng_len),
        .eng_wdata (eng_wdata),
        .eng_wreq  (eng_wreq),
        .eng_rdata (eng_rdata),
        .eng_rvalid(eng_rvalid),
        .eng_done  (eng_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int start_cnt = 0, last_start_cyc = 0;
    int done_a_cnt = 0, done_b_cnt = 0, err_a_cnt = 0, err_b_cnt = 0;
    int last_done_a_cyc = 0, last_done_b_cyc = 0;
    int wreq_a_cnt = 0, wreq_b_cnt = 0, rvalid_a_cnt = 0, rvalid_b_cnt = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: counts strobes and captures routed data words.
    always @(negedge clk) begin
        if (eng_start) begin start_cnt++; last_start_cyc = cyc; end
        if (done_a) begin done_a_cnt++; last_done_a_cyc = cyc; end
        if (done_b) begin done_b_cnt++; last_done_b_cyc = cyc; end
        if (done_a && err_a) err_a_cnt++;
        if (done_b && err_b) err_b_cnt++;
        if (wreq_a) wreq_a_cnt++;
        if (wreq_b) wreq_b_cnt++;
        if (rvalid_a) rvalid_a_cnt++;
        if (rvalid_b) rvalid_b_cnt++;
        if (wreq_a || wreq_b) obs_q.push_back(eng_wdata);
        if (rvalid_a || rvalid_b) obs_q.push_back(rdata);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_a = 0; req_b = 0; we_a = 0; we_b = 0;
        addr_a = '0; addr_b = '0; len_a = '0; len_b = '0;
        wdata_a = '0; wdata_b = '0;
        eng_wreq = 0; eng_rdata = '0; eng_rvalid = 0; eng_done = 0;
    endtask

    task automatic wait_start(input int s0);
        for (int i = 0; i < 40; i++) begin
            settle();
            if (start_cnt != s0) break;
            next_cycle();
        end
    endtask

    task automatic wait_done_a(input int d0);
        for (int i = 0; i < 40; i++) begin
            settle();
            if (done_a_cnt != d0) break;
            next_cycle();
        end
    endtask

    // Engine model: len data cycles then eng_done; returns inside the cycle
    // after eng_done. Expected words are queued as they are driven.
    task automatic engine_run(input logic port_b, input logic is_wr, input int len,
                              input logic [15:0] base, output int done_cyc);
        for (int i = 0; i < len; i++) begin
            next_cycle();
            wdata_a = base + 16'(i);
            wdata_b = ~(base + 16'(i));
            if (is_wr) begin
                eng_wreq = 1'b1;
                exp_q.push_back(port_b ? wdata_b : wdata_a);
            end else begin
                eng_rvalid = 1'b1;
                eng_rdata  = (base ^ 16'h5A5A) + 16'(i);
                exp_q.push_back(eng_rdata);
            end
        end
        next_cycle();
        eng_wreq = 1'b0; eng_rvalid = 1'b0; eng_done = 1'b1;
        done_cyc = cyc;
        next_cycle();
        eng_done = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        wdata_a = 16'h1234; eng_rdata = 16'h5678;
        repeat (3) next_cycle();
        rst = 1'b0;
        settle();
        n_checks++;
        if ({eng_start, eng_we, wreq_a, wreq_b, rvalid_a, rvalid_b, done_a, done_b, err_a, err_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0", {eng_start, eng_we, wreq_a, wreq_b, rvalid_a, rvalid_b, done_a, done_b, err_a, err_b});
        end
        n_checks++;
        if (eng_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", eng_addr); end
        n_checks++;
        if (eng_len !== 8'h0) begin n_fail++; $display("FAIL reset_len: got %h expected 0", eng_len); end
        n_checks++;
        if (eng_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", eng_wdata); end
        n_checks++;
        if (rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        idle_inputs();
    endtask

    task automatic test_single_write();
        int req_cyc, s0, da0, wb0, dcyc;
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_a = 1; we_a = 1; addr_a = 32'h0000_1000; len_a = 8'd4; req_cyc = cyc;
        s0 = start_cnt; da0 = done_a_cnt; wb0 = wreq_b_cnt;
        wait_start(s0);
        n_checks++;
        if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL wr_start_seen: got %0d starts expected %0d", start_cnt - s0, 1); end
        n_checks++;
        if (last_start_cyc - req_cyc !== 2) begin n_fail++; $display("FAIL wr_start_latency: got %0d expected 2", last_start_cyc - req_cyc); end
        n_checks++;
        if ({eng_we, eng_addr, eng_len} !== {1'b1, 32'h0000_1000, 8'd4}) begin
            n_fail++; $display("FAIL wr_cmd: got we=%b addr=%h len=%0d expected we=1 addr=00001000 len=4", eng_we, eng_addr, eng_len);
        end
        engine_run(1'b0, 1'b1, 4, 16'hA000, dcyc);
        req_a = 0;
        settle();
        n_checks++;
        if (done_a_cnt !== da0 + 1) begin n_fail++; $display("FAIL wr_done_count: got %0d expected 1", done_a_cnt - da0); end
        n_checks++;
        if (last_done_a_cyc - dcyc !== 1) begin n_fail++; $display("FAIL wr_done_latency: got %0d expected 1", last_done_a_cyc - dcyc); end
        n_checks++;
        if (err_a !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", err_a); end
        n_checks++;
        if (wreq_b_cnt !== wb0) begin n_fail++; $display("FAIL wr_wreq_b: got %0d pulses expected 0", wreq_b_cnt - wb0); end
        n_checks++;
        if (start_cnt !== s0 + 1) begin n_fail++; $display("FAIL wr_single_start: got %0d expected 1", start_cnt - s0); end
        n_checks++;
        if (obs_q.size() !== 4) begin n_fail++; $display("FAIL wr_word_count: got %0d expected 4", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wr_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    task automatic test_simultaneous();
        int s0, dcyc, dcyc2, db0;
        test_reset();
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_a = 1; we_a = 1; addr_a = 32'h0000_2000; len_a = 8'd2;
        req_b = 1; we_b = 0; addr_b = 32'h0000_3000; len_b = 8'd3;
        s0 = start_cnt;
        wait_start(s0);
        n_checks++;
        if (eng_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL tie_first_a: got addr %h expected 00002000", eng_addr); end
        engine_run(1'b0, 1'b1, 2, 16'hB000, dcyc);
        req_a = 0;
        next_cycle();
        req_a = 1; we_a = 0; addr_a = 32'h0000_2100; len_a = 8'd1;
        s0 = start_cnt; db0 = done_b_cnt;
        wait_start(s0);
        n_checks++;
        if (last_start_cyc - dcyc !== CSHI_CYCLES + 3) begin
            n_fail++; $display("FAIL tie_gap: got %0d cycles expected %0d", last_start_cyc - dcyc, CSHI_CYCLES + 3);
        end
        n_checks++;
        if ({eng_we, eng_addr} !== {1'b0, 32'h0000_3000}) begin
            n_fail++; $display("FAIL tie_second_b: got we=%b addr=%h expected we=0 addr=00003000", eng_we, eng_addr);
        end
        engine_run(1'b1, 1'b0, 3, 16'hC000, dcyc2);
        req_b = 0;
        settle();
        n_checks++;
        if (done_b_cnt !== db0 + 1 || last_done_b_cyc - dcyc2 !== 1) begin
            n_fail++; $display("FAIL tie_done_b: got count %0d lat %0d expected 1 1", done_b_cnt - db0, last_done_b_cyc - dcyc2);
        end
        s0 = start_cnt;
        next_cycle();
        wait_start(s0);
        n_checks++;
        if (eng_addr !== 32'h0000_2100) begin n_fail++; $display("FAIL tie_third_a: got addr %h expected 00002100", eng_addr); end
        engine_run(1'b0, 1'b0, 1, 16'hD000, dcyc);
        req_a = 0;
        settle();
        n_checks++;
        if (obs_q.size() !== 6) begin n_fail++; $display("FAIL tie_word_count: got %0d expected 6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL tie_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    task automatic test_read_b();
        int s0, dcyc, ra0, rb0;
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_b = 1; we_b = 0; addr_b = 32'h0000_4000; len_b = 8'd8;
        s0 = start_cnt; ra0 = rvalid_a_cnt; rb0 = rvalid_b_cnt;
        wait_start(s0);
        engine_run(1'b1, 1'b0, 8, 16'h7700, dcyc);
        req_b = 0;
        settle();
        n_checks++;
        if (rvalid_b_cnt - rb0 !== 8) begin n_fail++; $display("FAIL rd_rvalid_b: got %0d expected 8", rvalid_b_cnt - rb0); end
        n_checks++;
        if (rvalid_a_cnt !== ra0) begin n_fail++; $display("FAIL rd_rvalid_a: got %0d expected 0", rvalid_a_cnt - ra0); end
        n_checks++;
        if (obs_q.size() !== 8) begin n_fail++; $display("FAIL rd_word_count: got %0d expected 8", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rd_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    task automatic test_len_limits();
        logic [7:0] bad_len[2];
        int req_cyc, s0, da0, ea0, dcyc;
        bad_len[0] = 8'd0;
        bad_len[1] = 8'(MAX_LEN + 1);
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            req_a = 1; we_a = 1; addr_a = 32'h0000_6000; len_a = bad_len[k]; req_cyc = cyc;
            s0 = start_cnt; da0 = done_a_cnt; ea0 = err_a_cnt;
            wait_done_a(da0);
            n_checks++;
            if (last_done_a_cyc - req_cyc !== 2) begin n_fail++; $display("FAIL len_err_latency[%0d]: got %0d expected 2", bad_len[k], last_done_a_cyc - req_cyc); end
            n_checks++;
            if (err_a_cnt !== ea0 + 1) begin n_fail++; $display("FAIL len_err_flag[%0d]: got %0d expected 1", bad_len[k], err_a_cnt - ea0); end
            next_cycle();
            req_a = 0;
            repeat (4) next_cycle();
            settle();
            n_checks++;
            if (start_cnt !== s0) begin n_fail++; $display("FAIL len_err_no_start[%0d]: got %0d starts expected 0", bad_len[k], start_cnt - s0); end
            n_checks++;
            if (done_a_cnt !== da0 + 1) begin n_fail++; $display("FAIL len_err_single_done[%0d]: got %0d expected 1", bad_len[k], done_a_cnt - da0); end
        end
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_a = 1; we_a = 0; addr_a = 32'h0000_6100; len_a = 8'(MAX_LEN); req_cyc = cyc;
        s0 = start_cnt; da0 = done_a_cnt; ea0 = err_a_cnt;
        wait_start(s0);
        n_checks++;
        if (start_cnt !== s0 + 1 || last_start_cyc - req_cyc !== 2) begin
            n_fail++; $display("FAIL len_max_start: got %0d starts lat %0d expected 1 2", start_cnt - s0, last_start_cyc - req_cyc);
        end
        engine_run(1'b0, 1'b0, MAX_LEN, 16'h3100, dcyc);
        req_a = 0;
        settle();
        n_checks++;
        if (done_a_cnt !== da0 + 1 || err_a_cnt !== ea0) begin
            n_fail++; $display("FAIL len_max_done: got done %0d err %0d expected 1 0", done_a_cnt - da0, err_a_cnt - ea0);
        end
        n_checks++;
        if (obs_q.size() !== MAX_LEN) begin n_fail++; $display("FAIL len_max_words: got %0d expected %0d", obs_q.size(), MAX_LEN); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL len_max_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        int s0, da0, db0, dcyc;
        next_cycle();
        req_a = 1; we_a = 1; addr_a = 32'h0000_5000; len_a = 8'd4;
        s0 = start_cnt;
        wait_start(s0);
        next_cycle();
        eng_wreq = 1; wdata_a = 16'h1111;
        next_cycle();
        eng_wreq = 0; rst = 1;
        next_cycle();
        rst = 0; req_a = 0; da0 = done_a_cnt; db0 = done_b_cnt;
        eng_wreq = 1; eng_rvalid = 1; eng_rdata = 16'hCAFE; wdata_a = 16'h2222;
        settle();
        n_checks++;
        if ({eng_start, eng_we, wreq_a, wreq_b, rvalid_a, rvalid_b, done_a, done_b, err_a, err_b} !== 10'b0) begin
            n_fail++;
            $display("FAIL rst_mid_strobes: got %b expected 0", {eng_start, eng_we, wreq_a, wreq_b, rvalid_a, rvalid_b, done_a, done_b, err_a, err_b});
        end
        n_checks++;
        if ({eng_addr, eng_len, eng_wdata, rdata} !== 72'h0) begin
            n_fail++; $display("FAIL rst_mid_buses: got addr=%h len=%h wdata=%h rdata=%h expected 0", eng_addr, eng_len, eng_wdata, rdata);
        end
        next_cycle();
        eng_wreq = 0; eng_rvalid = 0; eng_rdata = '0;
        repeat (4) next_cycle();
        settle();
        n_checks++;
        if (done_a_cnt !== da0 || done_b_cnt !== db0) begin
            n_fail++; $display("FAIL rst_mid_no_done: got %0d/%0d expected 0/0", done_a_cnt - da0, done_b_cnt - db0);
        end
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_a = 1; we_a = 1; addr_a = 32'h0000_5100; len_a = 8'd1;
        req_b = 1; we_b = 1; addr_b = 32'h0000_5200; len_b = 8'd1;
        s0 = start_cnt;
        wait_start(s0);
        n_checks++;
        if (eng_addr !== 32'h0000_5100) begin n_fail++; $display("FAIL rst_mid_prio_a: got addr %h expected 00005100", eng_addr); end
        engine_run(1'b0, 1'b1, 1, 16'h4400, dcyc);
        req_a = 0;
        s0 = start_cnt;
        next_cycle();
        wait_start(s0);
        engine_run(1'b1, 1'b1, 1, 16'h4500, dcyc);
        req_b = 0;
        settle();
        n_checks++;
        if (obs_q.size() !== 2) begin n_fail++; $display("FAIL rst_mid_word_count: got %0d expected 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_mid_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    task automatic test_spurious();
        int s0, da0, db0, ra0, rb0, wa0, wb0, dcyc;
        s0 = start_cnt; da0 = done_a_cnt; db0 = done_b_cnt;
        ra0 = rvalid_a_cnt; rb0 = rvalid_b_cnt; wa0 = wreq_a_cnt; wb0 = wreq_b_cnt;
        next_cycle();
        eng_done = 1; eng_rvalid = 1; eng_wreq = 1; eng_rdata = 16'hBEEF;
        settle();
        n_checks++;
        if ({wreq_a, wreq_b, rvalid_a, rvalid_b} !== 4'b0) begin
            n_fail++; $display("FAIL spur_idle_route: got %b expected 0000", {wreq_a, wreq_b, rvalid_a, rvalid_b});
        end
        next_cycle();
        eng_done = 0; eng_rvalid = 0; eng_wreq = 0;
        repeat (3) next_cycle();
        settle();
        n_checks++;
        if (start_cnt !== s0 || done_a_cnt !== da0 || done_b_cnt !== db0) begin
            n_fail++; $display("FAIL spur_idle_state: got starts %0d dones %0d/%0d expected 0 0/0", start_cnt - s0, done_a_cnt - da0, done_b_cnt - db0);
        end
        exp_q.delete(); obs_q.delete();
        next_cycle();
        req_b = 1; we_b = 1; addr_b = 32'h0000_7000; len_b = 8'd2;
        wait_start(s0);
        engine_run(1'b1, 1'b1, 2, 16'h9900, dcyc);
        req_b = 0;
        req_a = 1; we_a = 0; addr_a = 32'h0000_7100; len_a = 8'd1;
        eng_done = 1; eng_rvalid = 1; eng_rdata = 16'hFACE;
        settle();
        n_checks++;
        if ({rvalid_a, rvalid_b} !== 2'b00) begin n_fail++; $display("FAIL spur_gap_rvalid: got %b expected 00", {rvalid_a, rvalid_b}); end
        next_cycle();
        eng_done = 0; eng_rvalid = 0;
        s0 = start_cnt;
        wait_start(s0);
        n_checks++;
        if (last_start_cyc - dcyc !== CSHI_CYCLES + 3) begin
            n_fail++; $display("FAIL spur_gap_timing: got %0d expected %0d", last_start_cyc - dcyc, CSHI_CYCLES + 3);
        end
        n_checks++;
        if (done_b_cnt !== db0 + 1 || done_a_cnt !== da0) begin
            n_fail++; $display("FAIL spur_gap_done: got %0d/%0d expected a=0 b=1", done_a_cnt - da0, done_b_cnt - db0);
        end
        n_checks++;
        if (rvalid_a_cnt !== ra0 || rvalid_b_cnt !== rb0 || wreq_a_cnt !== wa0 || wreq_b_cnt - wb0 !== 2) begin
            n_fail++; $display("FAIL spur_gap_strobes: got ra=%0d rb=%0d wa=%0d wb=%0d expected 0 0 0 2",
                               rvalid_a_cnt - ra0, rvalid_b_cnt - rb0, wreq_a_cnt - wa0, wreq_b_cnt - wb0);
        end
        engine_run(1'b0, 1'b0, 1, 16'h8800, dcyc);
        req_a = 0;
        settle();
        n_checks++;
        if (done_a_cnt !== da0 + 1 || err_a !== 1'b0) begin
            n_fail++; $display("FAIL spur_final_done_a: got %0d err=%b expected 1 err=0", done_a_cnt - da0, err_a);
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [15:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL spur_word: got %h expected %h", o, e); end
        end
        repeat (CSHI_CYCLES + 2) next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_read_b();
        test_len_limits();
        test_reset_mid_burst();
        test_spurious();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
